jump_branch_ctrl: RTL
=====================

# jump_branch_ctrl

Control-flow sequencer for the pipelined MIPS core: takes the decoded 3-bit jump/branch code of the instruction in ID, waits for its operands, then resolves BEQ/BNE/J/JAL/JR. It issues a registered one-cycle PC redirect with matching IF/ID flush and ID/EX bubble, plus a JAL link write. It sits between the ID stage decoder, the forwarding/hazard unit and the PC/pipeline-register enables, and keeps small performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID stage holds a real (non-bubble) instruction
- id_jump_branch  in  3  0 OTHERS, 1 BEQ, 2 BNE, 3 JR, 4 J, 7 JAL; 5/6 illegal
- id_pc_plus4  in  32  PC+4 of the ID instruction
- id_imm16  in  16  branch offset field
- id_instr_index  in  26  J/JAL target field
- rs_data, rt_data  in  32 each  forwarded operand values
- rs_ready, rt_ready  in  1 each  operand value is valid this cycle
- ext_flush  in  1  exception/EX-stage flush, highest priority after rst
- stall  out  1  combinational: hold PC and IF/ID, inject ID/EX bubble
- pc_redirect  out  1  registered: load pc_target into PC this cycle
- pc_target  out  32  registered redirect address
- flush_ifid  out  1  registered: IF/ID loads bubble at end of cycle
- bubble_idex  out  1  registered: ID/EX loads bubble at end of cycle
- link_we  out  1  registered: write link_data to $31
- link_data  out  32  registered link address
- illegal  out  1  registered one-cycle pulse on code 5 or 6
- cnt_ctrl, cnt_taken, cnt_stall  out  CNT_W each  resolved control-flow count, redirect count, stall-cycle count

## Operation
- Operand needs: BEQ/BNE need rs and rt; JR needs rs; J/JAL/OTHERS need none. need_ok = all needed *_ready bits high.
- Active = id_valid && state != REDIRECT && !ext_flush.
- stall = Active && code in {1,2,3} && !need_ok. Codes 0, 4, 5, 6 and 7 never stall.
- States: IDLE, WAIT_OPND, REDIRECT.
  - IDLE to WAIT_OPND when stall=1. WAIT_OPND stays while stall=1; cnt_stall += 1 per stalled cycle, including the first. ID inputs are held stable by the pipeline while stalled.
  - IDLE/WAIT_OPND with Active && need_ok and a control code: resolve this cycle, cnt_ctrl += 1. If taken, go to REDIRECT and cnt_taken += 1; else go to IDLE.
  - REDIRECT to IDLE unconditionally after one cycle. ID inputs in this cycle are wrong-path: ignored, not counted, no stall.
- Taken and target:
  - BEQ taken iff rs_data == rt_data; BNE taken iff they differ. Target = id_pc_plus4 + (sext(id_imm16) << 2), 32-bit wrap.
  - J/JAL always taken. Target = {id_pc_plus4[31:28], id_instr_index, 2'b00}.
  - JR always taken. Target = rs_data, no alignment check.
- JAL: link_data <= id_pc_plus4 and link_we <= 1 in the cycle after resolution, together with the redirect (no delay slot).
- Illegal codes: treated as OTHERS, plus illegal <= 1 for one cycle when Active.
- ext_flush: forces the next state to IDLE, drops any pending resolution, and clears the next-cycle pc_redirect/flush_ifid/bubble_idex/link_we. A REDIRECT already showing this cycle completes; ext_flush does not cancel outputs already driven.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset: state IDLE. stall=0, pc_redirect=0, pc_target=0, flush_ifid=0, bubble_idex=0, link_we=0, link_data=0, illegal=0, all counters 0. rst in any state, including REDIRECT or WAIT_OPND, takes effect at the next edge with no redirect emitted.
- Resolution in cycle T with taken: pc_redirect, flush_ifid and bubble_idex are 1 for exactly cycle T+1 and 0 at T+2. The taken penalty is 2 cycles; not-taken and OTHERS have 0.
- stall is same-cycle combinational, with no registered delay. When operands become ready at T, resolution happens at T.
- Back-to-back control instructions: the instruction entering ID at T+1 is ignored. The first valid resolution after a redirect is at T+2 or later.
- pc_target and link_data hold their last value when not asserted.

## Test plan
- BEQ, rs=rt=5, ready, pc_plus4=0x100, imm=0xFFFE -> at T+1 pc_redirect=1, pc_target=0xF8, flush_ifid=bubble_idex=1; cnt_ctrl=1, cnt_taken=1.
- BNE, rs=rt=5 -> no redirect at T+1, state IDLE, cnt_ctrl=1, cnt_taken=0.
- JR with rs_ready low for 3 cycles then rs=0x400 -> stall=1 for 3 cycles, cnt_stall=3, then redirect to 0x400 one cycle after ready.
- JAL at pc_plus4=0x3000_0010, index=0x40 -> at T+1 pc_target=0x3000_0100, link_we=1, link_data=0x3000_0010; a J presented at T+1 is ignored.
- Code 6 with id_valid -> illegal pulses 1 cycle, no stall, no redirect, cnt_ctrl unchanged.
- Taken BEQ resolved at T with rst=1 at T -> at T+1 all outputs 0, state IDLE. The same case with ext_flush=1 at T -> no redirect at T+1.

Source files
------------

// File: rtl/jump_branch_ctrl.sv
// Control-flow sequencer: resolves BEQ/BNE/J/JAL/JR in ID after operands are
// ready and issues a registered one-cycle PC redirect, IF/ID flush, ID/EX bubble and JAL link write.
//
// Ports:
//   clk, rst (sync, active-high)
//   id_valid, id_jump_branch, id_pc_plus4, id_imm16, id_instr_index : ID instruction
//   rs_data, rt_data, rs_ready, rt_ready : forwarded operands
//   ext_flush : exception/EX flush
//   stall (comb), pc_redirect, pc_target, flush_ifid, bubble_idex,
//   link_we, link_data, illegal (registered)
//   cnt_ctrl, cnt_taken, cnt_stall : performance counters
module jump_branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_jump_branch,
    input  logic [31:0]      id_pc_plus4,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_instr_index,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             ext_flush,
    output logic             stall,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             link_we,
    output logic [31:0]      link_data,
    output logic             illegal,
    output logic [CNT_W-1:0] cnt_ctrl,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPND,
        REDIRECT
    } state_e;

    state_e state_q, state_d;

    logic             redirect_q, redirect_d;
    logic [31:0]      target_q, target_d;
    logic             link_we_q, link_we_d;
    logic [31:0]      link_data_q, link_data_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_ctrl_q, cnt_ctrl_d;
    logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
    logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

    logic is_beq, is_bne, is_jr, is_j, is_jal, is_ill;
    logic is_ctrl, need_ok, active, resolve, taken;
    logic [31:0] br_target, j_target, tgt;

    always_comb begin
        is_beq  = (id_jump_branch == 3'd1);
        is_bne  = (id_jump_branch == 3'd2);
        is_jr   = (id_jump_branch == 3'd3);
        is_j    = (id_jump_branch == 3'd4);
        is_jal  = (id_jump_branch == 3'd7);
        is_ill  = (id_jump_branch == 3'd5) || (id_jump_branch == 3'd6);
        is_ctrl = is_beq || is_bne || is_jr || is_j || is_jal;

        need_ok = 1'b1;
        if (is_beq || is_bne) need_ok = rs_ready && rt_ready;
        else if (is_jr)       need_ok = rs_ready;

        // Instructions seen while a redirect is showing are wrong-path.
        active  = id_valid && (state_q != REDIRECT) && !ext_flush && !rst;
        stall   = active && (is_beq || is_bne || is_jr) && !need_ok;
        resolve = active && need_ok && is_ctrl;

        taken = 1'b0;
        if (is_beq)      taken = (rs_data == rt_data);
        else if (is_bne) taken = (rs_data != rt_data);
        else if (is_ctrl) taken = 1'b1;

        br_target = id_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
        j_target  = {id_pc_plus4[31:28], id_instr_index, 2'b00};
        tgt = br_target;
        if (is_jr)             tgt = rs_data;
        else if (is_j || is_jal) tgt = j_target;
    end

    always_comb begin
        state_d     = state_q;
        redirect_d  = resolve && taken;
        target_d    = target_q;
        link_we_d   = resolve && is_jal;
        link_data_d = link_data_q;
        illegal_d   = active && is_ill;
        cnt_ctrl_d  = cnt_ctrl_q + CNT_W'(resolve);
        cnt_taken_d = cnt_taken_q + CNT_W'(resolve && taken);
        cnt_stall_d = cnt_stall_q + CNT_W'(stall);

        if (resolve && taken)  target_d    = tgt;
        if (resolve && is_jal) link_data_d = id_pc_plus4;

        unique case (state_q)
            IDLE, WAIT_OPND: begin
                if (stall)                  state_d = WAIT_OPND;
                else if (resolve && taken)  state_d = REDIRECT;
                else                        state_d = IDLE;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (ext_flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            redirect_q  <= 1'b0;
            target_q    <= '0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            illegal_q   <= 1'b0;
            cnt_ctrl_q  <= '0;
            cnt_taken_q <= '0;
            cnt_stall_q <= '0;
        end else begin
            state_q     <= state_d;
            redirect_q  <= redirect_d;
            target_q    <= target_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            illegal_q   <= illegal_d;
            cnt_ctrl_q  <= cnt_ctrl_d;
            cnt_taken_q <= cnt_taken_d;
            cnt_stall_q <= cnt_stall_d;
        end
    end

    assign pc_redirect = redirect_q;
    assign flush_ifid  = redirect_q;
    assign bubble_idex = redirect_q;
    assign pc_target   = target_q;
    assign link_we     = link_we_q;
    assign link_data   = link_data_q;
    assign illegal     = illegal_q;
    assign cnt_ctrl    = cnt_ctrl_q;
    assign cnt_taken   = cnt_taken_q;
    assign cnt_stall   = cnt_stall_q;

endmodule
